// File: rtl/print_pkg.sv
// print_pkg: types and helpers shared by the print renderer and its command
// sequencer print_sched.
package print_pkg;

  // Table events handed over by the game FSM.
  typedef enum logic [1:0] {
    OP_NEW_ROUND = 2'd0,
    OP_PLAYER    = 2'd1,
    OP_DEALER    = 2'd2,
    OP_REVEAL    = 2'd3
  } sched_op_e;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_ACK   = 2'd2,
    S_WAIT  = 2'd3
  } sched_state_e;

  // Card code {suit[5:4], rank[3:0]}, rank 1..13.
  typedef logic [5:0] card_t;

  // Screen origin {y[14:8], x[7:0]}.
  typedef logic [14:0] orig_t;

  // Code drawn for a face-down card.
  localparam card_t CARD_BACK = 6'h3F;

  function automatic orig_t pack_orig(input logic [6:0] y, input logic [7:0] x);
    return {y, x};
  endfunction

  function automatic logic [7:0] orig_x(input orig_t o);
    return o[7:0];
  endfunction

  function automatic logic [6:0] orig_y(input orig_t o);
    return o[14:8];
  endfunction

endpackage

// File: rtl/print_sched.sv
// print_sched: turns table events into single print transactions, one in
// flight at a time, and tracks the slot position of each hand.
// Optional feature macro: PRINT_SCHED_HOLE_EN (dealer hole card drawn face-down
// and redrawn face-up on REVEAL). Undefined: all cards face-up, REVEAL no-op.
// Geometry must satisfy X0 + (MAX_CARDS-1)*X_STEP <= 159 so every slot is on
// screen; the x arithmetic is 8 bits wide.
module print_sched
  import print_pkg::*;
#(
  parameter int PLAYER_Y  = 80,
  parameter int DEALER_Y  = 10,
  parameter int X0        = 4,
  parameter int X_STEP    = 20,
  parameter int MAX_CARDS = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [5:0]  cmd_card,
  output logic        write,
  output logic        init,
  output logic [5:0]  card,
  output logic [14:0] orig,
  input  logic        waitrequest,
  output logic [2:0]  player_cnt,
  output logic [2:0]  dealer_cnt,
  output logic        overflow
);

  localparam logic [2:0] CNT_FULL = 3'(MAX_CARDS);

  sched_state_e state_reg;

`ifdef PRINT_SCHED_HOLE_EN
  card_t hole_reg;
  logic  dec_hole_load;
`endif

  // Decoded effect of the event currently offered on the command port.
  sched_op_e dec_op;
  logic      dec_issue;
  logic      dec_clear;
  logic      dec_inc_p;
  logic      dec_inc_d;
  logic      dec_full;
  logic      dec_init;
  card_t     dec_card;
  orig_t     dec_orig;

  // x of a slot: X0 + slot*X_STEP, kept to 8 bits.
  function automatic logic [7:0] slot_x(input logic [2:0] slot);
    return 8'(X0) + 8'(slot) * 8'(X_STEP);
  endfunction

  // Decode the offered event into counter updates and transaction fields.
  always_comb begin
    dec_op    = sched_op_e'(cmd_op);
    dec_issue = 1'b0;
    dec_clear = 1'b0;
    dec_inc_p = 1'b0;
    dec_inc_d = 1'b0;
    dec_full  = 1'b0;
    dec_init  = 1'b0;
    dec_card  = cmd_card;
    dec_orig  = '0;
`ifdef PRINT_SCHED_HOLE_EN
    dec_hole_load = 1'b0;
`endif
    case (dec_op)
      OP_NEW_ROUND: begin
        dec_issue = 1'b1;
        dec_clear = 1'b1;
        dec_init  = 1'b1;
        dec_card  = '0;
        dec_orig  = '0;
      end
      OP_PLAYER: begin
        // A full hand swallows the deal: flag it, draw nothing.
        if (player_cnt == CNT_FULL) begin
          dec_full = 1'b1;
        end else begin
          dec_issue = 1'b1;
          dec_inc_p = 1'b1;
          dec_orig  = pack_orig(7'(PLAYER_Y), slot_x(player_cnt));
        end
      end
      OP_DEALER: begin
        if (dealer_cnt == CNT_FULL) begin
          dec_full = 1'b1;
        end else begin
          dec_issue = 1'b1;
          dec_inc_d = 1'b1;
          dec_orig  = pack_orig(7'(DEALER_Y), slot_x(dealer_cnt));
`ifdef PRINT_SCHED_HOLE_EN
          // Slot 1 is the hole card: show the back, remember the face.
          if (dealer_cnt == 3'd1) begin
            dec_card      = CARD_BACK;
            dec_hole_load = 1'b1;
          end
`endif
        end
      end
      OP_REVEAL: begin
`ifdef PRINT_SCHED_HOLE_EN
        // Only meaningful once the hole slot has been dealt this round.
        if (dealer_cnt >= 3'd2) begin
          dec_issue = 1'b1;
          dec_card  = hole_reg;
          dec_orig  = pack_orig(7'(DEALER_Y), slot_x(3'd1));
        end
`endif
      end
      default: begin
      end
    endcase
  end

  // Sequencer FSM with registered handshake, transaction fields and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      cmd_ready  <= 1'b1;
      write      <= 1'b0;
      init       <= 1'b0;
      card       <= '0;
      orig       <= '0;
      player_cnt <= '0;
      dealer_cnt <= '0;
      overflow   <= 1'b0;
`ifdef PRINT_SCHED_HOLE_EN
      hole_reg   <= '0;
`endif
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (cmd_valid) begin
            if (dec_clear) begin
              player_cnt <= '0;
              dealer_cnt <= '0;
              overflow   <= 1'b0;
            end
            if (dec_inc_p) player_cnt <= player_cnt + 3'd1;
            if (dec_inc_d) dealer_cnt <= dealer_cnt + 3'd1;
            if (dec_full)  overflow   <= 1'b1;
`ifdef PRINT_SCHED_HOLE_EN
            if (dec_hole_load) hole_reg <= cmd_card;
`endif
            if (dec_issue) begin
              init      <= dec_init;
              card      <= dec_card;
              orig      <= dec_orig;
              cmd_ready <= 1'b0;
              state_reg <= S_ISSUE;
              // Strobe next cycle only if print is idle right now.
              write     <= !waitrequest;
            end
          end
        end
        S_ISSUE: begin
          if (write) begin
            write     <= 1'b0;
            state_reg <= S_ACK;
          end else begin
            write <= !waitrequest;
          end
        end
        S_ACK: begin
          // print needs a cycle to raise waitrequest after the strobe.
          state_reg <= S_WAIT;
        end
        S_WAIT: begin
          if (!waitrequest) begin
            cmd_ready <= 1'b1;
            state_reg <= S_IDLE;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          cmd_ready <= 1'b1;
          write     <= 1'b0;
        end
      endcase
    end
  end

endmodule
